// File: rtl/image_loader.sv
// Streams activation words into layer-1 memory with (ch,row,col) indices,
// fires one compute pulse per full frame, then waits for net_done.
module image_loader #(
  parameter int DATA_SIZE    = 64,
  parameter int NUM_CHANNELS = 1,
  parameter int INPUT_DIM    = 28
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_SIZE-1:0] s_data,
  input  logic                 s_last,
  input  logic                 net_done,
  output logic [DATA_SIZE-1:0] input_data,
  output logic [3:0][15:0]     input_index,
  output logic                 input_write_act,
  output logic                 compute,
  output logic                 busy,
  output logic [15:0]          frame_count,
  output logic                 frame_err
);

  localparam int PW = (INPUT_DIM > 1) ? $clog2(INPUT_DIM) : 1;
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [1:0] {LOAD, FIRE, WAIT} state_t;

  state_t        state, state_next;
  logic [CW-1:0] ch;
  logic [PW-1:0] row, col;
  logic          hs, col_end, row_end, ch_end, final_word;

  assign col_end    = (col == PW'(INPUT_DIM - 1));
  assign row_end    = (row == PW'(INPUT_DIM - 1));
  assign ch_end     = (ch == CW'(NUM_CHANNELS - 1));
  assign final_word = col_end && row_end && ch_end;

  // Ready is masked by reset so nothing is accepted while reset is held.
  assign s_ready = (state == LOAD) && !reset;
  assign hs      = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (hs && final_word) state_next = FIRE;
      FIRE:    state_next = WAIT;
      WAIT:    if (net_done) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch              <= '0;
      row             <= '0;
      col             <= '0;
      input_data      <= '0;
      input_index     <= '0;
      input_write_act <= 1'b0;
      compute         <= 1'b0;
      busy            <= 1'b0;
      frame_count     <= 16'd0;
      frame_err       <= 1'b0;
    end else begin
      input_write_act <= hs;
      compute         <= (state == FIRE);
      if (state == FIRE) frame_count <= frame_count + 16'd1;
      if (state == WAIT && net_done) busy <= 1'b0;
      if (hs) begin
        input_data  <= s_data;
        input_index <= {16'd0, 16'(ch), 16'(row), 16'(col)};
        busy        <= 1'b1;
        // Frame length is count-based; s_last only flags disagreement.
        if (s_last != final_word) frame_err <= 1'b1;
        if (col_end) begin
          col <= '0;
          if (row_end) begin
            row <= '0;
            if (ch_end) ch <= '0;
            else        ch <= ch + CW'(1);
          end else begin
            row <= row + PW'(1);
          end
        end else begin
          col <= col + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench: a small (2ch, 4x4) and a default (1ch, 28x28) loader.
module tb_image_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              reset[2], s_valid[2], s_last[2], net_done[2];
  logic [63:0]       s_data[2];
  logic              s_ready_w[2], wact[2], comp[2], busy_w[2], ferr[2];
  logic [63:0]       idata[2];
  logic [3:0][15:0]  idx[2];
  logic [15:0]       fcnt[2];

  image_loader #(.DATA_SIZE(64), .NUM_CHANNELS(2), .INPUT_DIM(4)) u_small (
    .clk(clk), .reset(reset[0]), .s_valid(s_valid[0]), .s_ready(s_ready_w[0]),
    .s_data(s_data[0]), .s_last(s_last[0]), .net_done(net_done[0]),
    .input_data(idata[0]), .input_index(idx[0]), .input_write_act(wact[0]),
    .compute(comp[0]), .busy(busy_w[0]), .frame_count(fcnt[0]), .frame_err(ferr[0]));

  image_loader u_dflt (
    .clk(clk), .reset(reset[1]), .s_valid(s_valid[1]), .s_ready(s_ready_w[1]),
    .s_data(s_data[1]), .s_last(s_last[1]), .net_done(net_done[1]),
    .input_data(idata[1]), .input_index(idx[1]), .input_write_act(wact[1]),
    .compute(comp[1]), .busy(busy_w[1]), .frame_count(fcnt[1]), .frame_err(ferr[1]));

  typedef struct packed {
    logic [63:0] data;
    logic [63:0] index;
    logic [31:0] cyc;
  } wexp_t;

  wexp_t wq0[$], wq1[$];
  int    cq0[$], cq1[$];
  int    checks = 0, errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wexp_t e;
    int    ce;
    bit    got;
    for (int i = 0; i < 2; i++) begin
      if (wact[i] === 1'b1) begin
        got = (i == 0) ? (wq0.size() > 0) : (wq1.size() > 0);
        if (!got) chk("unexpected_strobe", 64'd1, 64'd0);
        else begin
          e = (i == 0) ? wq0.pop_front() : wq1.pop_front();
          chk("wr_data", idata[i], e.data);
          chk("wr_index", idx[i], e.index);
          chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (comp[i] === 1'b1) begin
        got = (i == 0) ? (cq0.size() > 0) : (cq1.size() > 0);
        if (!got) chk("unexpected_compute", 64'd1, 64'd0);
        else begin
          ce = (i == 0) ? cq0.pop_front() : cq1.pop_front();
          chk("compute_cycle", 64'(cyc), 64'(ce));
        end
      end
    end
  end

  // Entered and left just after a falling edge.
  task automatic send_frame(int i, int n_words, int bad_last, int nd_word,
                            bit nd_fire, bit gaps);
    int d, total, hc, t;
    wexp_t e;
    d     = (i == 0) ? 4 : 28;
    total = (i == 0) ? 32 : 784;
    for (int k = 0; k < n_words; k++) begin
      s_valid[i] = 1'b1;
      s_data[i]  = 64'h3FF0_0000_0000_0000 + 64'(k);
      s_last[i]  = (k == total - 1) ^ (k == bad_last);
      if (k == nd_word) net_done[i] = 1'b1;
      t = 0;
      while (s_ready_w[i] !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) begin
        chk("ready_timeout", 64'd0, 64'd1);
        s_valid[i] = 1'b0;
        return;
      end
      @(posedge clk);
      #1 hc = cyc;
      e.data  = 64'h3FF0_0000_0000_0000 + 64'(k);
      e.index = {16'd0, 16'(k / (d * d)), 16'((k / d) % d), 16'(k % d)};
      e.cyc   = 32'(hc);
      if (i == 0) wq0.push_back(e); else wq1.push_back(e);
      if (k == total - 1) begin
        if (i == 0) cq0.push_back(hc + 1); else cq1.push_back(hc + 1);
      end
      @(negedge clk);
      s_valid[i]  = 1'b0;
      s_last[i]   = 1'b0;
      net_done[i] = 1'b0;
      if (k == total - 1 && nd_fire) begin
        net_done[i] = 1'b1;
        @(negedge clk);
        net_done[i] = 1'b0;
      end
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic release_frame(int i);
    chk("wait_ready_low", 64'(s_ready_w[i]), 64'd0);
    chk("wait_busy", 64'(busy_w[i]), 64'd1);
    net_done[i] = 1'b1;
    @(negedge clk);
    net_done[i] = 1'b0;
    chk("ready_after_done", 64'(s_ready_w[i]), 64'd1);
    chk("busy_after_done", 64'(busy_w[i]), 64'd0);
  endtask

  task automatic chk_zero(int i);
    chk("rst_wact", 64'(wact[i]), 64'd0);
    chk("rst_compute", 64'(comp[i]), 64'd0);
    chk("rst_busy", 64'(busy_w[i]), 64'd0);
    chk("rst_fcnt", 64'(fcnt[i]), 64'd0);
    chk("rst_ferr", 64'(ferr[i]), 64'd0);
    chk("rst_data", idata[i], 64'd0);
    chk("rst_index", idx[i], 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; s_valid[i] = 1'b0; s_last[i] = 1'b0;
      net_done[i] = 1'b0; s_data[i] = 64'd0;
    end
    repeat (3) @(negedge clk);
    chk("ready_in_reset", 64'(s_ready_w[0]), 64'd0);
    chk_zero(0);
    chk_zero(1);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    #1 chk("ready_after_reset", 64'(s_ready_w[0]), 64'd1);
    @(negedge clk);

    send_frame(0, 32, -1, -1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("fcnt_a", 64'(fcnt[0]), 64'd1);
    chk("ferr_a", 64'(ferr[0]), 64'd0);
    release_frame(0);

    // Bad s_last on word 5, net_done pulsed in LOAD and in FIRE.
    send_frame(0, 32, 5, 10, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("fcnt_b", 64'(fcnt[0]), 64'd2);
    chk("ferr_b", 64'(ferr[0]), 64'd1);
    release_frame(0);

    send_frame(0, 32, -1, -1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("fcnt_c", 64'(fcnt[0]), 64'd3);
    chk("ferr_sticky", 64'(ferr[0]), 64'd1);
    release_frame(0);

    send_frame(0, 10, -1, -1, 1'b0, 1'b0);
    reset[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero(0);
    chk("ready_in_reset2", 64'(s_ready_w[0]), 64'd0);
    reset[0] = 1'b0;
    @(negedge clk);
    send_frame(0, 32, -1, -1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("fcnt_d", 64'(fcnt[0]), 64'd1);
    chk("ferr_d", 64'(ferr[0]), 64'd0);
    release_frame(0);

    send_frame(1, 784, -1, -1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("fcnt_dflt", 64'(fcnt[1]), 64'd1);
    chk("ferr_dflt", 64'(ferr[1]), 64'd0);
    release_frame(1);

    repeat (3) @(negedge clk);
    chk("wq0_empty", 64'(wq0.size()), 64'd0);
    chk("wq1_empty", 64'(wq1.size()), 64'd0);
    chk("cq0_empty", 64'(cq0.size()), 64'd0);
    chk("cq1_empty", 64'(cq1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
